gcd_job_sequencer: RTL and testbench
====================================

// Module: gcd_job_sequencer
// PURPOSE
//   Upstream feeder and result collector for the GCD core. Buffers operand pairs {a,b} in a FIFO.
//   Issues one job at a time to the core using its start/ready/done handshake, then captures r.
//   Presents each result on a valid/ready output stream.
//   Sits between the AXI-Lite register/stream front end and the GCD core. At most one job is outstanding.
// PARAMETERS
//   DATA_W   32  operand/result width; must match the core
//   DEPTH    4   operand FIFO entries; power of 2, >= 2
//   CNT_W    16  width of the completed-job counter
// PORTS
//   clk         in   1       clock; all logic on the rising edge
//   rst         in   1       reset; asynchronous, active-high
//   s_valid     in   1       operand pair valid
//   s_ready     out  1       FIFO can accept a pair (= !full)
//   s_a         in   DATA_W  operand a
//   s_b         in   DATA_W  operand b
//   m_valid     out  1       result valid
//   m_ready     in   1       downstream accepts result
//   m_r         out  DATA_W  gcd result
//   core_start  out  1       one-cycle start pulse to the core
//   core_a      out  DATA_W  registered operand a to the core
//   core_b      out  DATA_W  registered operand b to the core
//   core_ready  in   1       core idle
//   core_done   in   1       one-cycle pulse; core_r is valid in the same cycle
//   core_r      in   DATA_W  core result
//   fifo_count  out  $clog2(DEPTH)+1  number of occupied FIFO entries
//   job_count   out  CNT_W   results accepted downstream; wraps modulo 2^CNT_W
//   busy        out  1       FSM != IDLE or FIFO not empty
// BEHAVIOUR
//   Reset (async, immediate):
//     - FIFO empties; FSM goes to IDLE.
//     - s_ready=1; m_valid=0; m_r=0; core_start=0; core_a=core_b=0; job_count=0.
//     - Reset mid-job discards the pair in flight. The system asserts the core reset together with rst.
//   FIFO push on s_valid&&s_ready. Full: s_ready=0 and the push is ignored.
//     Simultaneous push+pop when full is not allowed (s_ready low). When not full, push and pop in the same cycle both happen.
//   FSM states:
//     IDLE -> ISSUE   when the FIFO is not empty and core_ready=1.
//       Pop the head and register it into core_a/core_b.
//     ISSUE -> WAIT   core_start=1 for exactly this one cycle. core_ready is ignored from here until done.
//     WAIT -> HOLD    on core_done=1: m_r<=core_r, m_valid<=1. Stays in WAIT indefinitely otherwise.
//     HOLD -> IDLE    on m_valid&&m_ready: m_valid<=0, job_count+=1.
//       m_valid, once high, holds until accepted and m_r stays stable.
//   Latency (empty FIFO, idle core): push at edge N; core_start high in cycle N+2; m_valid high the cycle after core_done.
//   core_done outside WAIT is ignored.
//   Operands pass to the core unmodified; no width change.
// CONFIGURATION
//   GCD_ZERO_BYPASS_EN defined:
//     - On pop, if a==0 or b==0 the core is not started: m_r<=a|b (gcd(0,b)=b, gcd(0,0)=0).
//     - Pop goes to HOLD on the next edge, without the ISSUE/WAIT states.
//   Not defined: zero operands go to the core unchanged. The core never terminates on zero operands.
//     Software must not submit them; the FSM stays in WAIT until rst.
// STRUCTURE
//   Package gcd_seq_pkg: FSM state enum (IDLE, ISSUE, WAIT, HOLD) and the DATA_W default constant.
//   Sub-module gcd_pair_fifo: synchronous FIFO of width 2*DATA_W, parameterised by DEPTH.
//     Ports: push, pop, din, dout, full, empty, count. Wrap-around is by pointer MSB compare.
//   Top level: FSM, output registers, job counter, bypass logic.
// TESTING (bench models the core with gcd_core-equivalent timing)
//   1. Push (48,18), m_ready=1 -> one core_start pulse with core_a=48, core_b=18; m_r=6; job_count=1.
//   2. Push (7,13),(100,75),(64,256) back-to-back, m_ready=1 -> m_r 1,25,64 in order; exactly 3 core_start pulses.
//   3. DEPTH=4, m_ready=0, push 6 pairs -> 1 in core/HOLD, 4 in FIFO, s_ready=0, the 6th waits.
//      Release m_ready -> all 5 accepted pairs produce results in order.
//   4. GCD_ZERO_BYPASS_EN: push (0,35) then (0,0) -> m_r 35 then 0; no core_start.
//      Without the macro: (0,35) drives core_start with core_a=0, core_b=35.
//   5. Assert rst during WAIT -> same cycle: m_valid=0, fifo_count=0, core_start=0.
//      After release, push (12,8) -> m_r=4.
//   6. Toggle m_ready randomly during HOLD -> m_r stable while m_valid&&!m_ready; job_count increments only on handshake.

Source files
------------

// File: rtl/gcd_seq_pkg.sv
// rtl/gcd_seq_pkg.sv - shared types and defaults for the GCD job sequencer
package gcd_seq_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/gcd_pair_fifo.sv
// rtl/gcd_pair_fifo.sv - synchronous operand-pair FIFO, full/empty by pointer MSB compare
module gcd_pair_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit: equal low bits with differing MSB means full.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Advance read/write pointers; reset empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/gcd_job_sequencer.sv
// rtl/gcd_job_sequencer.sv - feeds buffered operand pairs to the GCD core, one job at a time (option: GCD_ZERO_BYPASS_EN)
module gcd_job_sequencer
  import gcd_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_W-1:0]         s_a,
  input  logic [DATA_W-1:0]         s_b,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_W-1:0]         m_r,
  output logic                      core_start,
  output logic [DATA_W-1:0]         core_a,
  output logic [DATA_W-1:0]         core_b,
  input  logic                      core_ready,
  input  logic                      core_done,
  input  logic [DATA_W-1:0]         core_r,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic [CNT_W-1:0]          job_count,
  output logic                      busy
);

  seq_state_e          state_q, state_d;
  logic [DATA_W-1:0]   core_a_q, core_a_d;
  logic [DATA_W-1:0]   core_b_q, core_b_d;
  logic                core_start_q, core_start_d;
  logic                m_valid_q, m_valid_d;
  logic [DATA_W-1:0]   m_r_q, m_r_d;
  logic [CNT_W-1:0]    job_count_q, job_count_d;

  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [2*DATA_W-1:0] head;
  logic [DATA_W-1:0]   head_a;
  logic [DATA_W-1:0]   head_b;
  logic                head_zero;

  gcd_pair_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid),
    .pop   (fifo_pop),
    .din   ({s_a, s_b}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head_a = head[2*DATA_W-1:DATA_W];
  assign head_b = head[DATA_W-1:0];

`ifdef GCD_ZERO_BYPASS_EN
  // A zero operand would hang the core; answer it locally instead (gcd(0,x) = x).
  assign head_zero = (head_a == '0) || (head_b == '0);
`else
  assign head_zero = 1'b0;
`endif

  assign s_ready    = !fifo_full;
  assign m_valid    = m_valid_q;
  assign m_r        = m_r_q;
  assign core_start = core_start_q;
  assign core_a     = core_a_q;
  assign core_b     = core_b_q;
  assign job_count  = job_count_q;
  assign busy       = (state_q != S_IDLE) || !fifo_empty;

  // Job FSM: pop and issue, wait for the core, hold the result until accepted.
  always_comb begin
    state_d      = state_q;
    fifo_pop     = 1'b0;
    core_a_d     = core_a_q;
    core_b_d     = core_b_q;
    core_start_d = 1'b0;
    m_valid_d    = m_valid_q;
    m_r_d        = m_r_q;
    job_count_d  = job_count_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && (head_zero || core_ready)) begin
          fifo_pop = 1'b1;
          if (head_zero) begin
            m_r_d     = head_a | head_b;
            m_valid_d = 1'b1;
            state_d   = S_HOLD;
          end else begin
            core_a_d     = head_a;
            core_b_d     = head_b;
            core_start_d = 1'b1;
            state_d      = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (core_done) begin
          m_r_d     = core_r;
          m_valid_d = 1'b1;
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (m_ready) begin
          m_valid_d   = 1'b0;
          job_count_d = job_count_q + CNT_W'(1);
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      core_a_q     <= '0;
      core_b_q     <= '0;
      core_start_q <= 1'b0;
      m_valid_q    <= 1'b0;
      m_r_q        <= '0;
      job_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      core_a_q     <= core_a_d;
      core_b_q     <= core_b_d;
      core_start_q <= core_start_d;
      m_valid_q    <= m_valid_d;
      m_r_q        <= m_r_d;
      job_count_q  <= job_count_d;
    end
  end

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// tb/tb_gcd_job_sequencer.sv - self-checking bench for gcd_job_sequencer with a behavioural core model
module tb_gcd_job_sequencer;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_a;
  logic [31:0] s_b;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_r;
  logic        core_start;
  logic [31:0] core_a;
  logic [31:0] core_b;
  logic        core_ready = 1'b1;
  logic        core_done  = 1'b0;
  logic [31:0] core_r     = '0;
  logic [2:0]  fifo_count;
  logic [15:0] job_count;
  logic        busy;

  gcd_job_sequencer #(.DATA_W(32), .DEPTH(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_a        (s_a),
    .s_b        (s_b),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_r        (m_r),
    .core_start (core_start),
    .core_a     (core_a),
    .core_b     (core_b),
    .core_ready (core_ready),
    .core_done  (core_done),
    .core_r     (core_r),
    .fifo_count (fifo_count),
    .job_count  (job_count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int lat_cfg = 3;
  int rand_mode = 0;
  int start_cnt = 0;
  int jobs_exp = 0;
  int rd_idx = 0;
  int iss_idx = 0;
  logic [63:0] iss_q[$];
  logic [31:0] res_q[$];
  logic        hold_prev = 1'b0;
  logic [31:0] hold_r = '0;

  // Core model state
  logic        cm_busy = 1'b0;
  logic [31:0] cm_a = '0;
  logic [31:0] cm_b = '0;
  int          cm_left = 0;

  function automatic logic [31:0] gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Core model: latches operands on start, pulses done after a delay; hangs on zero operands.
  always @(negedge clk) begin
    if (rst) begin
      cm_busy    <= 1'b0;
      core_done  <= 1'b0;
      core_ready <= 1'b1;
      core_r     <= '0;
    end else begin
      core_done <= 1'b0;
      if (core_start) start_cnt <= start_cnt + 1;
      if (!cm_busy && core_start) begin
        cm_a       <= core_a;
        cm_b       <= core_b;
        cm_busy    <= 1'b1;
        core_ready <= 1'b0;
        cm_left    <= (lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 8));
      end else if (cm_busy && cm_a != 0 && cm_b != 0) begin
        cm_left <= cm_left - 1;
        if (cm_left <= 1) begin
          core_done  <= 1'b1;
          core_r     <= gcd(cm_a, cm_b);
          cm_busy    <= 1'b0;
          core_ready <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode != 0) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int t;
    t = 0;
    while (!s_ready && t < 500) begin
      tick();
      t++;
    end
    chk("push_ready", {63'd0, s_ready}, 64'd1);
    s_valid = 1'b1;
    s_a = a;
    s_b = b;
`ifdef GCD_ZERO_BYPASS_EN
    if (a != 0 && b != 0) iss_q.push_back({a, b});
`else
    iss_q.push_back({a, b});
`endif
    res_q.push_back(gcd(a, b));
    jobs_exp++;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((rd_idx != res_q.size() || busy) && t < 3000) begin
      tick();
      t++;
    end
    chk("drain_timeout", {63'd0, (t < 3000)}, 64'd1);
  endtask

  task automatic wait_start(input int s0);
    int t;
    t = 0;
    while (start_cnt == s0 && t < 200) begin
      tick();
      t++;
    end
    chk("start_timeout", {63'd0, (t < 200)}, 64'd1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_s_ready"}, {63'd0, s_ready}, 64'd1);
    chk({tag, "_m_valid"}, {63'd0, m_valid}, 64'd0);
    chk({tag, "_core_start"}, {63'd0, core_start}, 64'd0);
    chk({tag, "_core_a"}, {32'd0, core_a}, 64'd0);
    chk({tag, "_core_b"}, {32'd0, core_b}, 64'd0);
    chk({tag, "_fifo_count"}, {61'd0, fifo_count}, 64'd0);
    chk({tag, "_job_count"}, {48'd0, job_count}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int s0;
    logic [31:0] k, a, b;
    rst = 1'b1;
    s_valid = 1'b0;
    s_a = '0;
    s_b = '0;
    m_ready = 1'b1;
    fork
      begin : stim
        #2;
        check_reset_state("reset");
        chk("reset_m_r", {32'd0, m_r}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        jobs_exp = 0;

        // Single job with exact issue timing
        s0 = start_cnt;
        push(32'd48, 32'd18);
        chk("t1_start_early", {63'd0, core_start}, 64'd0);
        tick();
        chk("t1_start", {63'd0, core_start}, 64'd1);
        chk("t1_core_a", {32'd0, core_a}, 64'd48);
        chk("t1_core_b", {32'd0, core_b}, 64'd18);
        tick();
        chk("t1_start_pulse", {63'd0, core_start}, 64'd0);
        drain();
        chk("t1_starts", 64'(start_cnt - s0), 64'd1);
        chk("t1_m_r", {32'd0, m_r}, 64'd6);
        chk("t1_job_count", {48'd0, job_count}, 64'(jobs_exp));

        // Back-to-back jobs
        s0 = start_cnt;
        push(32'd7, 32'd13);
        push(32'd100, 32'd75);
        push(32'd64, 32'd256);
        drain();
        chk("t2_starts", 64'(start_cnt - s0), 64'd3);
        chk("t2_job_count", {48'd0, job_count}, 64'(jobs_exp));

        // Backpressure fills the FIFO
        lat_cfg = 2;
        m_ready = 1'b0;
        push(32'd30, 32'd12);
        push(32'd21, 32'd14);
        push(32'd9, 32'd27);
        push(32'd100, 32'd10);
        push(32'd17, 32'd5);
        repeat (20) tick();
        chk("t3_fifo_count", {61'd0, fifo_count}, 64'd4);
        chk("t3_s_ready", {63'd0, s_ready}, 64'd0);
        chk("t3_m_valid", {63'd0, m_valid}, 64'd1);
        chk("t3_hold_r", {32'd0, m_r}, 64'd6);
        chk("t3_busy", {63'd0, busy}, 64'd1);
        m_ready = 1'b1;
        push(32'd40, 32'd64);
        drain();
        chk("t3_job_count", {48'd0, job_count}, 64'(jobs_exp));

        // Zero operands
        lat_cfg = 3;
        s0 = start_cnt;
`ifdef GCD_ZERO_BYPASS_EN
        push(32'd0, 32'd35);
        push(32'd0, 32'd0);
        drain();
        chk("t4_no_start", 64'(start_cnt - s0), 64'd0);
        chk("t4_m_r", {32'd0, m_r}, 64'd0);
        chk("t4_job_count", {48'd0, job_count}, 64'(jobs_exp));
        lat_cfg = 40;
        s0 = start_cnt;
        push(32'd9, 32'd6);
        wait_start(s0);
`else
        push(32'd0, 32'd35);
        wait_start(s0);
        chk("t4_starts", 64'(start_cnt - s0), 64'd1);
`endif

        // Reset while the core is running
        push(32'd5, 32'd5);
        repeat (3) tick();
        chk("t5_pre_fifo_count", {61'd0, fifo_count}, 64'd1);
        chk("t5_pre_busy", {63'd0, busy}, 64'd1);
        chk("t5_pre_m_valid", {63'd0, m_valid}, 64'd0);
        rst = 1'b1;
        #1;
        check_reset_state("t5_reset");
        tick();
        tick();
        rst = 1'b0;
        jobs_exp = 0;
        lat_cfg = 3;
        push(32'd12, 32'd8);
        drain();
        chk("t5_m_r", {32'd0, m_r}, 64'd4);
        chk("t5_job_count", {48'd0, job_count}, 64'(jobs_exp));

        // Random traffic with random downstream backpressure
        lat_cfg = 0;
        rand_mode = 1;
        for (int i = 0; i < 20; i++) begin
          k = 32'($urandom_range(1, 50));
          a = k * 32'($urandom_range(1, 200));
          b = k * 32'($urandom_range(1, 200));
          push(a, b);
        end
        drain();
        rand_mode = 0;
        m_ready = 1'b1;
        tick();
        chk("t6_job_count", {48'd0, job_count}, 64'(jobs_exp));
        chk("t6_all_issued", 64'(iss_idx), 64'(iss_q.size()));
      end
      begin : mon
        forever begin
          @(negedge clk);
          if (rst) begin
            rd_idx = res_q.size();
            iss_idx = iss_q.size();
            hold_prev = 1'b0;
          end else begin
            if (hold_prev) begin
              chk("hold_valid", {63'd0, m_valid}, 64'd1);
              chk("hold_stable", {32'd0, m_r}, {32'd0, hold_r});
            end
            if (core_start) begin
              chk("start_expected", {63'd0, (iss_idx < iss_q.size())}, 64'd1);
              if (iss_idx < iss_q.size()) begin
                chk("start_operands", {core_a, core_b}, iss_q[iss_idx]);
                iss_idx++;
              end
            end
            if (m_valid && m_ready) begin
              chk("result_expected", {63'd0, (rd_idx < res_q.size())}, 64'd1);
              if (rd_idx < res_q.size()) begin
                chk("result_value", {32'd0, m_r}, {32'd0, res_q[rd_idx]});
                rd_idx++;
              end
            end
            hold_prev = m_valid && !m_ready;
            hold_r = m_r;
          end
        end
      end
    join_any
    disable fork;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
